// File: rtl/sdr_init_seq.sv
// SDR SDRAM power-up initialisation sequencer: NOP wait, PRECHARGE ALL, N x AUTO REFRESH,
// LOAD MODE REGISTER, then sdr_init_done. Optional re-init from DONE under SDR_INIT_REINIT_EN.
module sdr_init_seq #(
   parameter int unsigned SDR_BW       = 2,
   parameter int unsigned PWRUP_CYCLES = 100,
   parameter int unsigned TRP          = 2,
   parameter int unsigned TRFC         = 7,
   parameter int unsigned TMRD         = 2,
   parameter int unsigned NUM_REFRESH  = 2,
   parameter logic [12:0] MODE_REG     = 13'h033
) (
   input  logic              sdram_clk,
   input  logic              sdram_resetn,
`ifdef SDR_INIT_REINIT_EN
   input  logic              reinit_req,
`endif
   output logic              sdr_cke,
   output logic              sdr_cs_n,
   output logic              sdr_ras_n,
   output logic              sdr_cas_n,
   output logic              sdr_we_n,
   output logic [1:0]        sdr_ba,
   output logic [12:0]       sdr_addr,
   output logic [SDR_BW-1:0] sdr_dqm,
   output logic              sdr_init_done
);

   localparam logic [3:0] CmdDesel = 4'b1111;
   localparam logic [3:0] CmdNop   = 4'b0111;
   localparam logic [3:0] CmdPre   = 4'b0010;
   localparam logic [3:0] CmdRef   = 4'b0001;
   localparam logic [3:0] CmdLmr   = 4'b0000;

   localparam logic [12:0] PreAllAddr = 13'h0400;

   typedef enum logic [2:0] {
      StPwrupWait,
      StTrpWait,
      StTrfcWait,
      StTmrdWait,
      StDone
   } state_e;

   state_e             state_q;
   logic [15:0]        wait_q;
   logic [7:0]         ref_q;
   logic               cke_q;
   logic [3:0]         cmd_q;
   logic [1:0]         ba_q;
   logic [12:0]        addr_q;
   logic [SDR_BW-1:0]  dqm_q;
   logic               done_q;

   // Each wait state issues the following command itself once its counter hits zero, so a
   // one-cycle wait yields back-to-back commands.
   always_ff @(posedge sdram_clk) begin
      if (!sdram_resetn) begin
         state_q <= StPwrupWait;
         wait_q  <= '0;
         ref_q   <= '0;
         cke_q   <= 1'b0;
         cmd_q   <= CmdDesel;
         ba_q    <= '0;
         addr_q  <= '0;
         dqm_q   <= '1;
         done_q  <= 1'b0;
      end else begin
         cke_q  <= 1'b1;
         cmd_q  <= CmdNop;
         ba_q   <= '0;
         addr_q <= '0;
         dqm_q  <= '1;
         unique case (state_q)
            StPwrupWait: begin
               // Counts up from reset so the cycle index equals the counter value.
               if (wait_q == 16'(PWRUP_CYCLES)) begin
                  cmd_q   <= CmdPre;
                  addr_q  <= PreAllAddr;
                  wait_q  <= 16'(TRP - 1);
                  state_q <= StTrpWait;
               end else begin
                  wait_q <= wait_q + 16'd1;
               end
            end
            StTrpWait: begin
               if (wait_q == '0) begin
                  cmd_q   <= CmdRef;
                  ref_q   <= ref_q + 8'd1;
                  wait_q  <= 16'(TRFC - 1);
                  state_q <= StTrfcWait;
               end else begin
                  wait_q <= wait_q - 16'd1;
               end
            end
            StTrfcWait: begin
               if (wait_q == '0) begin
                  if (ref_q == 8'(NUM_REFRESH)) begin
                     cmd_q   <= CmdLmr;
                     addr_q  <= MODE_REG;
                     wait_q  <= 16'(TMRD - 1);
                     state_q <= StTmrdWait;
                  end else begin
                     cmd_q  <= CmdRef;
                     ref_q  <= ref_q + 8'd1;
                     wait_q <= 16'(TRFC - 1);
                  end
               end else begin
                  wait_q <= wait_q - 16'd1;
               end
            end
            StTmrdWait: begin
               if (wait_q == '0) begin
                  done_q  <= 1'b1;
                  state_q <= StDone;
               end else begin
                  wait_q <= wait_q - 16'd1;
               end
            end
            StDone: begin
`ifdef SDR_INIT_REINIT_EN
               if (reinit_req) begin
                  done_q  <= 1'b0;
                  cmd_q   <= CmdPre;
                  addr_q  <= PreAllAddr;
                  ref_q   <= '0;
                  wait_q  <= 16'(TRP - 1);
                  state_q <= StTrpWait;
               end
`endif
            end
            default: begin
               state_q <= StPwrupWait;
               wait_q  <= '0;
               ref_q   <= '0;
               done_q  <= 1'b0;
            end
         endcase
      end
   end

   assign sdr_cke                                  = cke_q;
   assign {sdr_cs_n, sdr_ras_n, sdr_cas_n, sdr_we_n} = cmd_q;
   assign sdr_ba                                   = ba_q;
   assign sdr_addr                                 = addr_q;
   assign sdr_dqm                                  = dqm_q;
   assign sdr_init_done                            = done_q;

endmodule

// File: tb/tb_sdr_init_seq.sv
// Directed bench for sdr_init_seq: default and overridden timing, mid-sequence reset,
// and DONE behaviour (re-init when SDR_INIT_REINIT_EN is defined, terminal otherwise).
module tb_sdr_init_seq;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rstn  = 1'b0;
   logic rstn2 = 1'b0;
   logic reinit_req = 1'b0;

   logic        cke, cs_n, ras_n, cas_n, we_n, done;
   logic [1:0]  ba, dqm;
   logic [12:0] addr;
   logic        cke2, cs_n2, ras_n2, cas_n2, we_n2, done2;
   logic [1:0]  ba2, dqm2;
   logic [12:0] addr2;

   int n_checks = 0;
   int n_fail   = 0;

   sdr_init_seq u_dut (
      .sdram_clk     (clk),
      .sdram_resetn  (rstn),
`ifdef SDR_INIT_REINIT_EN
      .reinit_req    (reinit_req),
`endif
      .sdr_cke       (cke),
      .sdr_cs_n      (cs_n),
      .sdr_ras_n     (ras_n),
      .sdr_cas_n     (cas_n),
      .sdr_we_n      (we_n),
      .sdr_ba        (ba),
      .sdr_addr      (addr),
      .sdr_dqm       (dqm),
      .sdr_init_done (done)
   );

   sdr_init_seq #(
      .PWRUP_CYCLES (4),
      .TRP          (1),
      .TRFC         (1),
      .TMRD         (1),
      .NUM_REFRESH  (8)
   ) u_dut_fast (
      .sdram_clk     (clk),
      .sdram_resetn  (rstn2),
`ifdef SDR_INIT_REINIT_EN
      .reinit_req    (1'b0),
`endif
      .sdr_cke       (cke2),
      .sdr_cs_n      (cs_n2),
      .sdr_ras_n     (ras_n2),
      .sdr_cas_n     (cas_n2),
      .sdr_we_n      (we_n2),
      .sdr_ba        (ba2),
      .sdr_addr      (addr2),
      .sdr_dqm       (dqm2),
      .sdr_init_done (done2)
   );

   // Packed view: {cke, cs_n, ras_n, cas_n, we_n, ba, addr, dqm, init_done}
   logic [22:0] obs, obs2;
   assign obs  = {cke, cs_n, ras_n, cas_n, we_n, ba, addr, dqm, done};
   assign obs2 = {cke2, cs_n2, ras_n2, cas_n2, we_n2, ba2, addr2, dqm2, done2};

   localparam logic [22:0] RstVec = {1'b0, 4'b1111, 2'b00, 13'h0000, 2'b11, 1'b0};

   // Expected pins at cycle n for a sequence whose PRECHARGE lands at cycle p.
   function automatic logic [22:0] exp_vec(input int n, input int p, input int trp,
                                           input int trfc, input int nref, input int tmrd,
                                           input logic [12:0] mode);
      logic [3:0]  cmd;
      logic [12:0] a;
      int          l;
      cmd = 4'b0111;
      a   = 13'h0000;
      l   = p + trp + nref * trfc;
      if (n == p) begin
         cmd = 4'b0010;
         a   = 13'h0400;
      end
      for (int k = 0; k < nref; k++)
         if (n == p + trp + k * trfc) cmd = 4'b0001;
      if (n == l) begin
         cmd = 4'b0000;
         a   = mode;
      end
      return {1'b1, cmd, 2'b00, a, 2'b11, (n >= l + tmrd)};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rstn = 1'b0;
      for (int i = 0; i < 5; i++) begin
         step();
         n_checks++;
         if (obs !== RstVec) begin
            n_fail++;
            $display("FAIL reset_hold cyc%0d: got %h expected %h", i, obs, RstVec);
         end
      end
   endtask

   task automatic test_defaults();
      rstn = 1'b1;
      for (int n = 0; n < 130; n++) begin
         step();
         n_checks++;
         if (obs !== exp_vec(n, 100, 2, 7, 2, 2, 13'h033)) begin
            n_fail++;
            $display("FAIL defaults cyc%0d: got %h expected %h", n, obs,
                     exp_vec(n, 100, 2, 7, 2, 2, 13'h033));
         end
      end
   endtask

`ifdef SDR_INIT_REINIT_EN
   task automatic test_reinit();
      reinit_req = 1'b1;
      for (int n = 130; n < 170; n++) begin
         step();
         n_checks++;
         if (obs !== exp_vec(n, 130, 2, 7, 2, 2, 13'h033)) begin
            n_fail++;
            $display("FAIL reinit cyc%0d: got %h expected %h", n, obs,
                     exp_vec(n, 130, 2, 7, 2, 2, 13'h033));
         end
         reinit_req = (n == 134);
      end
      reinit_req = 1'b0;
   endtask
`else
   task automatic test_terminal();
      for (int n = 130; n < 1130; n++) begin
         step();
         n_checks++;
         if (obs !== exp_vec(n, 100, 2, 7, 2, 2, 13'h033)) begin
            n_fail++;
            $display("FAIL terminal cyc%0d: got %h expected %h", n, obs,
                     exp_vec(n, 100, 2, 7, 2, 2, 13'h033));
         end
      end
   endtask
`endif

   task automatic test_mid_reset();
      rstn = 1'b0;
      step();
      step();
      rstn = 1'b1;
      for (int n = 0; n < 105; n++) begin
         step();
         n_checks++;
         if (obs !== exp_vec(n, 100, 2, 7, 2, 2, 13'h033)) begin
            n_fail++;
            $display("FAIL mid_reset_pre cyc%0d: got %h expected %h", n, obs,
                     exp_vec(n, 100, 2, 7, 2, 2, 13'h033));
         end
      end
      rstn = 1'b0;
      step();
      n_checks++;
      if (obs !== RstVec) begin
         n_fail++;
         $display("FAIL mid_reset_pulse: got %h expected %h", obs, RstVec);
      end
      rstn = 1'b1;
      for (int n = 0; n < 126; n++) begin
         step();
         n_checks++;
         if (obs !== exp_vec(n, 100, 2, 7, 2, 2, 13'h033)) begin
            n_fail++;
            $display("FAIL mid_reset_post cyc%0d: got %h expected %h", n, obs,
                     exp_vec(n, 100, 2, 7, 2, 2, 13'h033));
         end
      end
   endtask

   task automatic test_overrides();
      n_checks++;
      if (obs2 !== RstVec) begin
         n_fail++;
         $display("FAIL overrides_reset: got %h expected %h", obs2, RstVec);
      end
      rstn2 = 1'b1;
      for (int n = 0; n < 21; n++) begin
         step();
         n_checks++;
         if (obs2 !== exp_vec(n, 4, 1, 1, 8, 1, 13'h033)) begin
            n_fail++;
            $display("FAIL overrides cyc%0d: got %h expected %h", n, obs2,
                     exp_vec(n, 4, 1, 1, 8, 1, 13'h033));
         end
      end
   endtask

   initial begin
      test_reset();
      test_defaults();
`ifdef SDR_INIT_REINIT_EN
      test_reinit();
`else
      test_terminal();
`endif
      test_mid_reset();
      test_overrides();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/sdr_init_seq.md
Name: sdr_init_seq

Overview:
- Power-up initialisation sequencer for the SDR SDRAM command bus.
- After reset it drives the JEDEC init sequence on the SDRAM pins: power-up wait, PRECHARGE ALL, N x AUTO REFRESH, LOAD MODE REGISTER.
- When the sequence completes it raises sdr_init_done, which the bus monitor and the core command scheduler use as the hand-over point.
- The top-level pin mux selects this block's outputs while sdr_init_done=0.

Parameters:
- SDR_BW, 2, SDRAM byte width (dqm width)
- PWRUP_CYCLES, 100, NOP cycles after reset release before PRECHARGE ALL (1..65535)
- TRP, 2, cycles from PRECHARGE to next command (>=1)
- TRFC, 7, cycles from AUTO REFRESH to next command (>=1)
- TMRD, 2, cycles from LOAD MODE REGISTER to sdr_init_done (>=1)
- NUM_REFRESH, 2, number of AUTO REFRESH commands (1..255)
- MODE_REG, 13'h033, value driven on sdr_addr during LOAD MODE REGISTER (CL3, BL8, sequential)

Ports:
- sdram_clk  input  1  SDRAM clock; all logic on rising edge
- sdram_resetn  input  1  synchronous active-low reset
- sdr_cke  output  1  clock enable
- sdr_cs_n  output  1  chip select
- sdr_ras_n  output  1  RAS
- sdr_cas_n  output  1  CAS
- sdr_we_n  output  1  write enable
- sdr_ba  output  2  bank address
- sdr_addr  output  13  address / mode word
- sdr_dqm  output  SDR_BW  data mask
- sdr_init_done  output  1  init complete, level

Behaviour:
- Clocking and reset: single clock sdram_clk; reset is sdram_resetn, synchronous, active-low. All outputs are registered.
- Reset values (any edge sampling sdram_resetn=0):
  - sdr_cke=0, {cs_n,ras_n,cas_n,we_n}=4'b1111 (deselect)
  - sdr_ba=0, sdr_addr=0, sdr_dqm=all ones, sdr_init_done=0
  - state=PWRUP_WAIT, counters=0
- Cycle numbering: edge 0 is the first rising edge sampling sdram_resetn=1. "Cycle n" is the output value registered at edge n.
- Command encodings {cs_n,ras_n,cas_n,we_n}:
  - NOP=0111, PRECHARGE=0010, AUTO_REFRESH=0001, LOAD_MODE=0000
  - In every non-command cycle out of reset: NOP with addr=0, ba=0.
- Out of reset: sdr_cke=1 from cycle 0 onward. sdr_dqm stays all ones throughout.
- States:
  - PWRUP_WAIT: NOP for cycles 0..PWRUP_CYCLES-1, then PRECHARGE.
  - PRECHARGE: one cycle at cycle P=PWRUP_CYCLES, addr=13'h0400 (A10=1, all banks), ba=0; then TRP_WAIT.
  - TRP_WAIT: NOP until next command in cycle P+TRP.
  - REFRESH: one cycle per command; refresh k (0-based) issued at cycle P+TRP+k*TRFC, addr=0, ba=0; TRFC_WAIT between refreshes. An internal 8-bit refresh counter counts issued refreshes.
  - LOAD_MODE: one cycle at cycle L=P+TRP+NUM_REFRESH*TRFC, addr=MODE_REG, ba=0; then TMRD_WAIT.
  - TMRD_WAIT / DONE: sdr_init_done=1 from cycle L+TMRD and held until reset. DONE drives NOP permanently, cke=1.
- Waits of exactly 1 cycle give back-to-back commands with no NOP between.
- Exactly one non-NOP command per cycle; no command other than the four above is ever driven.
- Wait counter: 16 bits, loaded on each command and decremented; no wrap is possible for legal parameters.
- Reset mid-sequence (any state): full restart from PWRUP_WAIT. sdr_init_done must not glitch high.
- Defaults: PRECHARGE at 100, AUTO_REFRESH at 102 and 109, LOAD_MODE at 116, sdr_init_done at 118.

Optional Feature:
- Macro: SDR_INIT_REINIT_EN.
- When defined:
  - Adds port reinit_req (input, 1).
  - In DONE, reinit_req=1 sampled at edge E: sdr_init_done=0 and PRECHARGE ALL in cycle E, skipping PWRUP_WAIT. The sequence then proceeds as above with P=E.
  - reinit_req is ignored in all other states.
  - A reset during re-init behaves as a normal reset.
- When undefined:
  - Port absent.
  - DONE is terminal until reset.

Test Plan:
- Reset hold: sdram_resetn=0 for 5 cycles -> cke=0, cmd=1111, dqm=2'b11, addr=0, ba=0, init_done=0 each cycle.
- Defaults, reset released -> NOP cycles 0..99; PRECHARGE addr=0x400 at 100; AUTO_REFRESH at 102 and 109; LOAD_MODE addr=0x033 ba=0 at 116; init_done=1 from 118 onward. Checker flags any other non-NOP command.
- Reset pulse of 1 cycle during cycle 105 -> reset values next cycle. After re-release: PRECHARGE 100 cycles later, init_done=0 until the full sequence completes.
- Overrides PWRUP_CYCLES=4, TRP=1, TRFC=1, TMRD=1, NUM_REFRESH=8 -> PRECHARGE at 4; AUTO_REFRESH at 5..12 back-to-back; LOAD_MODE at 13; init_done at 14.
- SDR_INIT_REINIT_EN defined:
  - reinit_req=1 sampled at edge 130 (defaults) -> init_done=0 and PRECHARGE at 130; AUTO_REFRESH at 132 and 139; LOAD_MODE at 146; init_done at 148.
  - reinit_req pulse at 135 -> ignored.
- Without SDR_INIT_REINIT_EN: after init_done, 1000 further cycles -> only NOP, init_done stays 1.
